// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file and its clear engine.
package reg_file_mp_pkg;

    localparam int RF_DATA_WIDTH_DEF = 32;
    localparam int RF_ADDR_WIDTH_DEF = 5;
    localparam int RF_NUM_RD_DEF     = 2;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear engine: walks every entry once after reset or on clr_req, zeroing one entry per cycle.
module reg_file_clr_fsm
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  clr_wen,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    rf_state_t             state;
    rf_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [ADDR_WIDTH-1:0] clr_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // The pointer wraps to 0 on its own after the last entry, ready for the next clear.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_done    = 1'b0;
        clr_wen     = 1'b0;
        clr_addr    = clr_ptr;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = RF_CLEAR;
                end
            end
            RF_CLEAR: begin
                clr_wen     = 1'b1;
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    clr_done  = 1'b1;
                    state_nxt = RF_IDLE;
                end
            end
            default: begin
                state_nxt = RF_CLEAR;
            end
        endcase
    end

    assign busy = (state == RF_CLEAR);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async read ports, 2 write ports, built-in clear engine.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH_DEF,
    parameter int NUM_RD     = RF_NUM_RD_DEF,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         clr_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];

    logic                  clr_wen;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  wr0_en;
    logic [ADDR_WIDTH-1:0] wr0_addr;
    logic [DATA_WIDTH-1:0] wr0_data;
    logic                  wr1_en;
    logic [ADDR_WIDTH-1:0] wr1_addr;
    logic [DATA_WIDTH-1:0] wr1_data;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    reg_file_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_wen  (clr_wen),
        .clr_addr (clr_addr)
    );

    // The clear engine borrows write port 0 and blocks both caller ports while it runs.
    always_comb begin
        wr1_addr = waddr1;
        wr1_data = wdata1;
        if (clr_wen) begin
            wr0_en   = 1'b1;
            wr0_addr = clr_addr;
            wr0_data = '0;
            wr1_en   = 1'b0;
        end else begin
            wr0_en   = wen0 && !is_zero_reg(waddr0);
            wr0_addr = waddr0;
            wr0_data = wdata0;
            wr1_en   = wen1 && !is_zero_reg(waddr1);
        end
    end

    // Port 1 is written last so it wins an address collision with port 0.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            rf[wr0_addr] <= wr0_data;
        end
        if (wr1_en) begin
            rf[wr1_addr] <= wr1_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;

        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = rf[ra];
`ifdef REG_FILE_BYPASS_EN
            if (wen1 && (waddr1 == ra)) begin
                rd = wdata1;
            end else if (wen0 && (waddr0 == ra)) begin
                rd = wdata0;
            end
`endif
            // Masking is applied last so forwarding can never override it.
            if (busy || is_zero_reg(ra)) begin
                rd = '0;
            end
        end

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    end

endmodule
